// File: rtl/timer2_countdown.sv
// Count-down timer sharing timer2's 6-bit hh:mm:ss format.
// Software loads a start time and starts it; the block decrements once per tick and pulses done_o when it reaches zero.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | holding a loaded value, waiting for start_i
// ST_RUN  | counting down (also while paused)
// ST_DONE | expired, value 00:00:00, waiting for load_i
module timer2_countdown #(
    parameter int CLK_DIV = 1,
    parameter int CNT_W   = 26
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [5:0] sec_i,
    input  logic [5:0] min_i,
    input  logic [5:0] hour_i,
    input  logic       start_i,
    input  logic       pause_i,
    output logic [5:0] sec_o,
    output logic [5:0] min_o,
    output logic [5:0] hour_o,
    output logic       running_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLK_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pre_q, pre_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       min_q, min_d;
    logic [5:0]       hour_q, hour_d;
    logic             done_q, done_d;

    logic [5:0]       ld_sec, ld_min, ld_hour;
    logic [5:0]       dec_sec, dec_min, dec_hour;
    logic             val_zero, dec_zero, tick;

    assign ld_sec   = (sec_i  > 6'd59) ? 6'd59 : sec_i;
    assign ld_min   = (min_i  > 6'd59) ? 6'd59 : min_i;
    assign ld_hour  = (hour_i > 6'd23) ? 6'd23 : hour_i;

    assign tick     = (pre_q == PRE_LAST);
    assign val_zero = (sec_q == 6'd0) && (min_q == 6'd0) && (hour_q == 6'd0);

    // Borrow chain; only evaluated for nonzero values since RUN never holds 00:00:00.
    always_comb begin
        dec_sec  = sec_q;
        dec_min  = min_q;
        dec_hour = hour_q;
        if (sec_q != 6'd0) begin
            dec_sec = sec_q - 6'd1;
        end else if (min_q != 6'd0) begin
            dec_sec = 6'd59;
            dec_min = min_q - 6'd1;
        end else if (hour_q != 6'd0) begin
            dec_sec  = 6'd59;
            dec_min  = 6'd59;
            dec_hour = hour_q - 6'd1;
        end
    end

    assign dec_zero = (dec_sec == 6'd0) && (dec_min == 6'd0) && (dec_hour == 6'd0);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        done_d  = 1'b0;

        if (load_i) begin
            sec_d   = ld_sec;
            min_d   = ld_min;
            hour_d  = ld_hour;
            pre_d   = '0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        pre_d = '0;
                        if (val_zero) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!pause_i) begin
                        if (tick) begin
                            pre_d  = '0;
                            sec_d  = dec_sec;
                            min_d  = dec_min;
                            hour_d = dec_hour;
                            if (dec_zero) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            pre_d = pre_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            hour_q  <= 6'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            done_q  <= done_d;
        end
    end

    assign sec_o     = sec_q;
    assign min_o     = min_q;
    assign hour_o    = hour_q;
    assign running_o = (state_q == ST_RUN);
    assign done_o    = done_q;

endmodule

// File: tb/tb_timer2_countdown.sv
// Bench for timer2_countdown: a vector table plus long countdown and pause sequences, checked through an expectation queue.
// Two instances share the stimulus: one with a per-cycle tick, one dividing by 4.
module tb_timer2_countdown;

    logic       clk;
    logic       rst, ld, st, ps;
    logic [5:0] s_in, m_in, h_in;

    logic [5:0] s1, m1, h1, s4, m4, h4;
    logic       run1, done1, run4, done4;

    int errors = 0;
    int checks = 0;

    timer2_countdown #(.CLK_DIV(1), .CNT_W(26)) u1 (
        .clk_i(clk), .reset_i(rst), .load_i(ld), .sec_i(s_in), .min_i(m_in), .hour_i(h_in),
        .start_i(st), .pause_i(ps), .sec_o(s1), .min_o(m1), .hour_o(h1),
        .running_o(run1), .done_o(done1)
    );

    timer2_countdown #(.CLK_DIV(4), .CNT_W(26)) u4 (
        .clk_i(clk), .reset_i(rst), .load_i(ld), .sec_i(s_in), .min_i(m_in), .hour_i(h_in),
        .start_i(st), .pause_i(ps), .sec_o(s4), .min_o(m4), .hour_o(h4),
        .running_o(run4), .done_o(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, ld, st, ps;
        logic [5:0] h, m, s;
        logic [5:0] eh, em, es;
        logic       erun, edone;
    } vec_t;

    typedef struct {
        string       nm;
        int          d;
        logic [19:0] v;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];

    function automatic logic [19:0] pack_t(int t, bit r, bit dn);
        logic [5:0] hh, mm, ss;
        hh = 6'(t / 3600);
        mm = 6'((t / 60) % 60);
        ss = 6'(t % 60);
        return {hh, mm, ss, r, dn};
    endfunction

    function automatic vec_t mk(logic r, logic l, logic sa, logic p,
                                logic [5:0] h, logic [5:0] m, logic [5:0] s,
                                logic [5:0] eh, logic [5:0] em, logic [5:0] es,
                                logic er, logic ed);
        vec_t x;
        x.rst = r; x.ld = l; x.st = sa; x.ps = p;
        x.h = h; x.m = m; x.s = s;
        x.eh = eh; x.em = em; x.es = es; x.erun = er; x.edone = ed;
        return x;
    endfunction

    task automatic set_in(logic r, logic l, logic sa, logic p,
                          logic [5:0] h, logic [5:0] m, logic [5:0] s);
        rst = r; ld = l; st = sa; ps = p;
        h_in = h; m_in = m; s_in = s;
    endtask

    task automatic push(string nm, int d, logic [19:0] v);
        exp_t e;
        e.nm = nm; e.d = d; e.v = v;
        sbq.push_back(e);
    endtask

    task automatic check_val(string nm, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // Advance one edge, then retire every queued expectation against its instance.
    task automatic step();
        exp_t        e;
        logic [19:0] act;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = (e.d == 4) ? {h4, m4, s4, run4, done4} : {h1, m1, s1, run1, done1};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %0d:%0d:%0d run=%0b done=%0b, want %0d:%0d:%0d run=%0b done=%0b",
                         e.nm, act[19:14], act[13:8], act[7:2], act[1], act[0],
                         e.v[19:14], e.v[13:8], e.v[7:2], e.v[1], e.v[0]);
            end
        end
    endtask

    initial begin
        int  en, rem, done_cycle;
        bit  fin, p, dexp;

        set_in(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0);

        //          rst ld st ps  h      m      s      eh     em     es     run  done
        tbl.push_back(mk(1, 0, 0, 0, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  0, 0)); // reset
        tbl.push_back(mk(0, 1, 0, 0, 6'd30, 6'd60, 6'd63, 6'd23, 6'd59, 6'd59, 0, 0)); // clamp
        tbl.push_back(mk(0, 0, 0, 0, 6'd0,  6'd0,  6'd0,  6'd23, 6'd59, 6'd59, 0, 0)); // hold in IDLE
        tbl.push_back(mk(0, 1, 1, 0, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  0, 0)); // load wins over start
        tbl.push_back(mk(0, 0, 1, 0, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  0, 1)); // zero start -> DONE
        tbl.push_back(mk(0, 0, 0, 0, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  0, 0)); // pulse is one cycle
        tbl.push_back(mk(0, 0, 1, 0, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  0, 0)); // start ignored in DONE
        tbl.push_back(mk(0, 1, 1, 0, 6'd0,  6'd0,  6'd5,  6'd0,  6'd0,  6'd5,  0, 0)); // load+start -> IDLE
        tbl.push_back(mk(0, 0, 0, 1, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd5,  0, 0)); // pause in IDLE inert
        tbl.push_back(mk(0, 0, 1, 0, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd5,  1, 0)); // enter RUN
        tbl.push_back(mk(0, 0, 0, 0, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd4,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd3,  1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 6'd9,  6'd9,  6'd9,  6'd0,  6'd0,  6'd0,  0, 0)); // reset mid-RUN wins
        tbl.push_back(mk(0, 0, 1, 0, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  0, 1)); // start after reset -> DONE
        tbl.push_back(mk(0, 0, 0, 0, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 6'd0,  6'd0,  6'd1,  6'd0,  6'd0,  6'd1,  0, 0)); // load exits DONE
        tbl.push_back(mk(0, 0, 1, 0, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd1,  1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 6'd2,  6'd3,  6'd7,  6'd2,  6'd3,  6'd7,  0, 0)); // load on expiry tick
        tbl.push_back(mk(0, 0, 1, 0, 6'd0,  6'd0,  6'd0,  6'd2,  6'd3,  6'd7,  1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 6'd0,  6'd0,  6'd0,  6'd2,  6'd3,  6'd7,  1, 0)); // paused
        tbl.push_back(mk(0, 0, 1, 1, 6'd0,  6'd0,  6'd0,  6'd2,  6'd3,  6'd7,  1, 0)); // start while paused
        tbl.push_back(mk(0, 0, 0, 0, 6'd0,  6'd0,  6'd0,  6'd2,  6'd3,  6'd6,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 6'd0,  6'd0,  6'd0,  6'd2,  6'd3,  6'd5,  1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  6'd0,  0, 0)); // abort RUN by load

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].rst, tbl[i].ld, tbl[i].st, tbl[i].ps, tbl[i].h, tbl[i].m, tbl[i].s);
            push($sformatf("vec%0d", i), 1,
                 {tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].erun, tbl[i].edone});
            step();
        end

        // 00:01:02 countdown, one tick per cycle.
        set_in(1, 0, 0, 0, 6'd0, 6'd0, 6'd0); push("a_rst", 1, pack_t(0, 0, 0));  step();
        set_in(0, 1, 0, 0, 6'd0, 6'd1, 6'd2); push("a_load", 1, pack_t(62, 0, 0)); step();
        set_in(0, 0, 1, 0, 6'd0, 6'd0, 6'd0); push("a_start", 1, pack_t(62, 1, 0)); step();
        set_in(0, 0, 0, 0, 6'd0, 6'd0, 6'd0);
        for (int k = 1; k <= 63; k++) begin
            rem = (k <= 62) ? 62 - k : 0;
            push($sformatf("a_cyc%0d", k), 1, pack_t(rem, rem != 0, k == 62));
            step();
        end

        // 01:00:00 borrow across the hour.
        set_in(1, 0, 0, 0, 6'd0, 6'd0, 6'd0); push("b_rst", 1, pack_t(0, 0, 0));     step();
        set_in(0, 1, 0, 0, 6'd1, 6'd0, 6'd0); push("b_load", 1, pack_t(3600, 0, 0)); step();
        set_in(0, 0, 1, 0, 6'd0, 6'd0, 6'd0); push("b_start", 1, pack_t(3600, 1, 0)); step();
        set_in(0, 0, 0, 0, 6'd0, 6'd0, 6'd0);
        for (int k = 1; k <= 3601; k++) begin
            rem = (k <= 3600) ? 3600 - k : 0;
            push($sformatf("b_cyc%0d", k), 1, pack_t(rem, rem != 0, k == 3600));
            step();
        end

        // Divide-by-4 with a 10-cycle pause after 2 enabled cycles.
        set_in(1, 0, 0, 0, 6'd0, 6'd0, 6'd0); push("c_rst", 4, pack_t(0, 0, 0));  step();
        set_in(0, 1, 0, 0, 6'd0, 6'd0, 6'd3); push("c_load", 4, pack_t(3, 0, 0)); step();
        set_in(0, 0, 1, 0, 6'd0, 6'd0, 6'd0); push("c_start", 4, pack_t(3, 1, 0)); step();
        en = 0; fin = 0; done_cycle = -1;
        for (int k = 1; k <= 26; k++) begin
            p = (k >= 3 && k <= 12);
            set_in(0, 0, 0, p, 6'd0, 6'd0, 6'd0);
            if (!fin && !p) en++;
            rem  = 3 - en / 4;
            dexp = !fin && (rem == 0);
            push($sformatf("c_cyc%0d", k), 4, pack_t(rem, !fin && !dexp, dexp));
            if (dexp) fin = 1;
            step();
            if (done4 && done_cycle < 0) done_cycle = k;
        end
        check_val("c_expiry_cycle", done_cycle, 22);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer2_countdown.md
Name: timer2_countdown

Overview:
- Count-down companion to the up-counting timer2 block, using the same 6-bit sec/min/hour time format.
- Software loads a start time; the block decrements once per second-tick to 00:00:00, then raises a one-cycle done pulse.
- Its outputs drive the same display path as timer2, so sec_o/min_o/hour_o have the same widths and ranges.

Parameters:
- CLK_DIV, 1, clock cycles per one-second tick; must be >=1. Default 1 makes every enabled cycle a tick, for simulation.
- CNT_W, 26, width of the internal prescaler counter; must satisfy 2^CNT_W >= CLK_DIV.

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- reset_i  input  1  synchronous, active-high reset.
- load_i  input  1  1-cycle strobe; captures sec_i/min_i/hour_i.
- sec_i  input  6  load value, seconds, 0..59.
- min_i  input  6  load value, minutes, 0..59.
- hour_i  input  6  load value, hours, 0..23.
- start_i  input  1  1-cycle strobe; begins counting from IDLE.
- pause_i  input  1  level; while high in RUN, count and prescaler freeze.
- sec_o  output  6  current seconds.
- min_o  output  6  current minutes.
- hour_o  output  6  current hours.
- running_o  output  1  high in RUN state, including while paused.
- done_o  output  1  one-cycle pulse when the count reaches zero.

Behaviour:
- Reset: all of the following clear to 0 on the first rising clk_i edge with reset_i=1:
  - sec_o, min_o, hour_o
  - running_o, done_o
  - the prescaler
  - state, which goes to IDLE
- Reset overrides every other input in the same cycle, including mid-RUN.
- Input priority per cycle: reset_i > load_i > start_i > tick.
- States:
  - IDLE: holding a loaded value.
  - RUN: counting down.
  - DONE: expired, value 00:00:00.
- load_i (any state):
  - Registers the inputs, clamped: sec/min >59 become 59; hour >23 becomes 23.
  - Clears the prescaler; next state is IDLE, so load during RUN aborts the countdown.
  - done_o=0 that cycle.
- start_i:
  - In IDLE with a nonzero value: go to RUN; prescaler starts at 0.
  - In IDLE with 00:00:00: go to DONE, and done_o pulses on the same edge.
  - Ignored in RUN and DONE.
- Prescaler:
  - Increments only in RUN with pause_i=0.
  - tick = (prescaler==CLK_DIV-1); on tick the prescaler wraps to 0.
  - First decrement occurs CLK_DIV enabled cycles after entering RUN.
- Decrement on tick, borrow chain:
  - sec>0: sec-1.
  - sec==0, min>0: sec=59, min-1.
  - sec==0, min==0, hour>0: sec=59, min=59, hour-1.
- Expiry: when a tick produces 00:00:00, on that same edge:
  - state goes to DONE;
  - done_o=1 for exactly one cycle;
  - running_o=0.
- DONE:
  - Value holds at 0; done_o stays 0 after the pulse.
  - Exit only via load_i or reset_i.
- Pause:
  - pause_i=1 in RUN: outputs and prescaler hold; running_o stays 1.
  - Releasing pause_i resumes from the held prescaler value; no tick is lost or added.
  - pause_i has no effect outside RUN.
- Outputs are registered, with no combinational path from inputs. Arithmetic is unsigned 6-bit, and values never leave their legal ranges.
- Simultaneous events:
  - load_i with start_i: load wins; start is ignored and state is IDLE.
  - load_i on the expiry tick: load wins; no done pulse.
  - start_i during pause: ignored.

Test Plan:
- Reset mid-RUN (CLK_DIV=1, loaded 00:00:05, started, 2 ticks elapsed) then reset_i=1 for one edge -> on that edge all outputs 0, state IDLE; start_i afterwards goes to DONE with done_o pulse.
- CLK_DIV=1, load 00:01:02, start -> sec_o sequence per cycle: 01, 00, then 00:00:59, then down to 0. done_o pulses once, exactly 62 cycles after start; running_o falls on the same edge.
- Borrow across hours: CLK_DIV=1, load 01:00:00, start -> after 1 tick 00:59:59; after 3600 ticks 00:00:00 with done_o=1 for one cycle.
- Pause and prescaler: CLK_DIV=4, load 00:00:03, start, pause_i=1 for 10 cycles after 2 enabled cycles -> first decrement 2 enabled cycles after release; total expiry at start + 12 + 10 cycles.
- Clamp and zero start: load sec=63, min=60, hour=30 -> outputs 23:59:59. Load 00:00:00 plus start -> done_o pulse next edge, running_o never 1.
- Simultaneous events:
  - load_i and start_i same cycle -> state IDLE, running_o=0.
  - load_i on the expiry tick -> loaded value shown, no done_o.
